// File: rtl/matmul_pkg.sv
// Shared constants, address-width helper and FSM state type for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned MAT_MAX_SIZE  = 10;
  localparam int unsigned MAT_WIDTH_IN  = 8;
  localparam int unsigned MAT_WIDTH_OUT = 16;

  function automatic int unsigned addr_width(input int unsigned max_size);
    return (max_size * max_size > 1) ? $clog2(max_size * max_size) : 1;
  endfunction

  localparam int unsigned MAT_ADDR_W = addr_width(MAT_MAX_SIZE);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters (k fastest) and the A/B operand address arithmetic.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int unsigned AddrW = MAT_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [7:0]       n_i,
  output logic [AddrW-1:0] a_addr_o,
  output logic [AddrW-1:0] b_addr_o,
  output logic             k_zero_o,
  output logic             last_o
);

  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] n_m1;
  logic [31:0] a_full, b_full;

  assign n_m1 = n_i - 8'd1;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (step_i) begin
      if (k_q == n_m1) begin
        k_d = '0;
        if (j_q == n_m1) begin
          j_d = '0;
          i_d = (i_q == n_m1) ? 8'd0 : i_q + 8'd1;
        end else begin
          j_d = j_q + 8'd1;
        end
      end else begin
        k_d = k_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign a_full   = 32'(i_q) * 32'(n_i) + 32'(k_q);
  assign b_full   = 32'(k_q) * 32'(n_i) + 32'(j_q);
  assign a_addr_o = a_full[AddrW-1:0];
  assign b_addr_o = b_full[AddrW-1:0];
  assign k_zero_o = (k_q == 8'd0);
  assign last_o   = (i_q == n_m1) && (j_q == n_m1) && (k_q == n_m1);

endmodule

// File: rtl/matmul_sequencer.sv
// Square matrix-multiply sequencer: issues A/B reads into an external MAC, writes results.
// Optional MATMUL_SEQ_PERF_EN adds a 32-bit busy-cycle counter output.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_SIZE  = MAT_MAX_SIZE,
  parameter int unsigned WIDTH_IN  = MAT_WIDTH_IN,
  parameter int unsigned WIDTH_OUT = MAT_WIDTH_OUT,
  localparam int unsigned AddrW    = addr_width(MAX_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           size,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AddrW-1:0]     a_addr,
  output logic [AddrW-1:0]     b_addr,
  input  logic [WIDTH_IN-1:0]  a_data,
  input  logic [WIDTH_IN-1:0]  b_data,
  output logic [WIDTH_IN-1:0]  mac_inA,
  output logic [WIDTH_IN-1:0]  mac_inB,
  output logic                 mac_clear,
  output logic                 mac_valid_in,
  input  logic [WIDTH_OUT-1:0] mac_out,
  input  logic                 mac_valid_out,
`ifdef MATMUL_SEQ_PERF_EN
  output logic [31:0]          cycles,
`endif
  output logic                 r_we,
  output logic [AddrW-1:0]     r_addr,
  output logic [WIDTH_OUT-1:0] r_data
);

  state_e state_q, state_d;
  logic [7:0] n_q, n_d, vcnt_q, vcnt_d;
  logic [AddrW-1:0] cell_q, cell_d;
  logic err_q, err_d, issue_v_q, issue_v_d, kzero_q, kzero_d;
  logic gen_clear, gen_step, k_zero, last_triple;
  logic size_ok, capture, last_cell;

  matmul_addr_gen #(
    .AddrW(AddrW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (gen_clear),
    .step_i  (gen_step),
    .n_i     (n_q),
    .a_addr_o(a_addr),
    .b_addr_o(b_addr),
    .k_zero_o(k_zero),
    .last_o  (last_triple)
  );

  assign size_ok   = (size >= 8'd2) && (32'(size) <= MAX_SIZE);
  // Partial sums also arrive during ISSUE when the MAC is short; only the Nth per cell is kept.
  assign capture   = ((state_q == StIssue) || (state_q == StDrain)) && mac_valid_out;
  assign r_we      = capture && (vcnt_q == n_q - 8'd1);
  assign last_cell = (32'(cell_q) == 32'(n_q) * 32'(n_q) - 32'd1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    vcnt_d    = vcnt_q;
    cell_d    = cell_q;
    err_d     = 1'b0;
    issue_v_d = 1'b0;
    kzero_d   = 1'b0;
    gen_clear = 1'b0;
    gen_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (size_ok) begin
            n_d       = size;
            vcnt_d    = '0;
            cell_d    = '0;
            gen_clear = 1'b1;
            state_d   = StIssue;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        gen_step  = 1'b1;
        issue_v_d = 1'b1;
        kzero_d   = k_zero;
        if (last_triple) state_d = StDrain;
      end
      StDrain: begin
        if (r_we && last_cell) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
    if (capture) begin
      if (r_we) begin
        vcnt_d = '0;
        cell_d = cell_q + AddrW'(1);
      end else begin
        vcnt_d = vcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_q       <= '0;
      vcnt_q    <= '0;
      cell_q    <= '0;
      err_q     <= 1'b0;
      issue_v_q <= 1'b0;
      kzero_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      vcnt_q    <= vcnt_d;
      cell_q    <= cell_d;
      err_q     <= err_d;
      issue_v_q <= issue_v_d;
      kzero_q   <= kzero_d;
    end
  end

  // Operand data returns one cycle after its address, aligned with issue_v_q.
  assign mac_valid_in = issue_v_q;
  assign mac_clear    = issue_v_q & kzero_q;
  assign mac_inA      = issue_v_q ? a_data : '0;
  assign mac_inB      = issue_v_q ? b_data : '0;
  assign busy         = (state_q == StIssue) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign err          = err_q;
  assign r_addr       = cell_q;
  assign r_data       = r_we ? mac_out : '0;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == StIdle) && start && size_ok) begin
      cycles_d = '0;
    end else if (busy) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with A/B memory, 2-cycle MAC model and a write scoreboard.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int unsigned AW = MAT_ADDR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    size = '0;
  logic          busy, done, err;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  logic [7:0]    a_data, b_data, mac_inA, mac_inB;
  logic          mac_clear, mac_valid_in, mac_valid_out, r_we;
  logic [15:0]   mac_out, r_data;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0]   cycles;
`endif

  matmul_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .size         (size),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .a_addr       (a_addr),
    .b_addr       (b_addr),
    .a_data       (a_data),
    .b_data       (b_data),
    .mac_inA      (mac_inA),
    .mac_inB      (mac_inB),
    .mac_clear    (mac_clear),
    .mac_valid_in (mac_valid_in),
    .mac_out      (mac_out),
    .mac_valid_out(mac_valid_out),
`ifdef MATMUL_SEQ_PERF_EN
    .cycles       (cycles),
`endif
    .r_we         (r_we),
    .r_addr       (r_addr),
    .r_data       (r_data)
  );

  always #5 clk = ~clk;

  logic [7:0] a_mem [100];
  logic [7:0] b_mem [100];

  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  // MAC model: accumulate, then two pipeline stages; every op emits a valid partial sum.
  logic [15:0] acc, p1_d, p2_d, sum_next;
  logic        p1_v, p2_v;
  assign sum_next = (mac_clear ? 16'd0 : acc) + 16'(mac_inA) * 16'(mac_inB);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; p1_d <= '0; p2_d <= '0; p1_v <= 1'b0; p2_v <= 1'b0;
    end else begin
      if (mac_valid_in) acc <= sum_next;
      p1_v <= mac_valid_in;
      p1_d <= sum_next;
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end
  assign mac_out       = p2_d;
  assign mac_valid_out = p2_v;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;
  int vin_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_valid_in) vin_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      if (r_we) begin
        wr_cnt++;
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("r_addr", 32'(r_addr), mon_e.addr);
          check("r_data", 32'(r_data), mon_e.data);
        end
      end
    end
  end

  task automatic push_expected(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        int unsigned s = 0;
        for (int k = 0; k < n; k++) s += a_mem[i*n+k] * b_mem[k*n+j];
        e.addr = i * n + j;
        e.data = s & 32'hFFFF;
        sb.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int sz);
    @(posedge clk);
    #1 start = 1'b1;
    size = 8'(sz);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid_in", 32'(mac_valid_in), 0);
    check("rst_clear", 32'(mac_clear), 0);
    check("rst_r_we", 32'(r_we), 0);
    check("rst_a_addr", 32'(a_addr), 0);
    check("rst_b_addr", 32'(b_addr), 0);
    check("rst_inA", 32'(mac_inA), 0);
    check("rst_inB", 32'(mac_inB), 0);
    check("rst_r_data", 32'(r_data), 0);
    check("rst_r_addr", 32'(r_addr), 0);
  endtask

  task automatic run_job(input int n);
    int t = 0;
    push_expected(n);
    vin_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    pulse_start(n);
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("job_finished", 32'(t < 3000), 1);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    check("valid_in_cycles", 32'(vin_cnt), 32'(n * n * n));
    check("done_pulses", 32'(done_cnt), 1);
    check("err_pulses", 32'(err_cnt), 0);
    check("busy_after", 32'(busy), 0);
`ifdef MATMUL_SEQ_PERF_EN
    check("cycles", cycles, 32'(busy_cnt));
    repeat (4) @(negedge clk);
    check("cycles_hold", cycles, 32'(busy_cnt));
`endif
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < 100; i++) begin
      a_mem[i] = (i < n * n) ? 8'(i + 1) : 8'd0;
      b_mem[i] = (i < n * n) ? 8'(i + 1) : 8'd0;
    end
  endtask

  task automatic load_n2_identity();
    for (int i = 0; i < 100; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) a_mem[i] = 8'(i + 1);
    b_mem[0] = 8'd1;
    b_mem[3] = 8'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int wr0;
    load_n2_identity();
    #23;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, A=[1,2,3,4], B=I
    run_job(2);

    // N=3, A=B=[1..9]
    load_seq(3);
    run_job(3);

    // N=10, all 255: every cell wraps to 60426
    for (int i = 0; i < 100; i++) begin
      a_mem[i] = 8'd255;
      b_mem[i] = 8'd255;
    end
    wr0 = wr_cnt;
    run_job(10);
    check("n10_writes", 32'(wr_cnt - wr0), 100);

    // Illegal sizes
    err_cnt = 0; busy_cnt = 0; wr0 = wr_cnt;
    pulse_start(1);
    repeat (3) @(negedge clk);
    check("err_size1", 32'(err_cnt), 1);
    pulse_start(11);
    repeat (3) @(negedge clk);
    check("err_size11", 32'(err_cnt), 2);
    check("err_busy", 32'(busy_cnt), 0);
    check("err_no_write", 32'(wr_cnt - wr0), 0);

    // N=3 with a stray start mid-ISSUE, then reset mid-DRAIN
    load_seq(3);
    push_expected(3);
    err_cnt = 0;
    pulse_start(3);
    repeat (5) @(negedge clk);
    check("mid_issue_busy", 32'(busy), 1);
    pulse_start(2);
    @(negedge clk);
    check("stray_start_valid", 32'(mac_valid_in), 1);
    check("stray_start_err", 32'(err_cnt), 0);
    t = 0;
    while (mac_valid_in && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("issue_ended", 32'(t < 100), 1);
    check("in_drain_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    check("no_resume_busy", 32'(busy), 0);
    check("no_resume_done", 32'(done_cnt), 0);

    load_n2_identity();
    run_job(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 10: largest square matrix dimension accepted.
REQ-002 SHALL have parameter WIDTH_IN, default 8: element width of A and B.
REQ-003 SHALL have parameter WIDTH_OUT, default 16: result width.
REQ-004 SHALL have port clk  input  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have ports start  input  1 and size  input  8: start request and matrix dimension N.
REQ-007 SHALL have outputs busy  1, done  1 and err  1: job status.
REQ-008 SHALL have outputs a_addr and b_addr, each clog2(MAX_SIZE^2) bits, and inputs a_data and b_data, each WIDTH_IN: A/B memory reads with 1-cycle read latency.
REQ-009 SHALL have outputs mac_inA and mac_inB  WIDTH_IN, mac_clear  1 and mac_valid_in  1, and inputs mac_out  WIDTH_OUT and mac_valid_out  1: the MAC pipeline port.
REQ-010 SHALL have outputs r_we  1, r_addr  clog2(MAX_SIZE^2) and r_data  WIDTH_OUT: result memory write port.

Function
REQ-011 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-012 IDLE: on start=1, size SHALL be checked.
- 2 <= size <= MAX_SIZE: latch N, clear the i/j/k counters, go to ISSUE, busy=1 from the next cycle.
- Otherwise: pulse err for 1 cycle and stay in IDLE.
REQ-013 ISSUE SHALL present one (i,j,k) triple per cycle with no bubbles.
- Order: k fastest, then j, then i.
- a_addr = i*N+k; b_addr = k*N+j.
REQ-014 One cycle after each address, the block SHALL drive mac_inA=a_data, mac_inB=b_data and mac_valid_in=1, with mac_clear=1 only when the issued k=0.
REQ-015 After triple (N-1,N-1,N-1) is issued, the block SHALL go to DRAIN.
REQ-016 The block SHALL count mac_valid_out pulses modulo N. On each pulse where the count equals N-1, it SHALL assert r_we=1 for 1 cycle with r_data=mac_out and r_addr = the row-major index of the next cell (0,1,...,N^2-1).
REQ-017 DRAIN SHALL exit to DONE on the cycle after the N^2-th r_we.
REQ-018 DONE SHALL pulse done=1 for 1 cycle, deassert busy and return to IDLE.
REQ-019 start while not in IDLE SHALL be ignored, with no err and no state change.
REQ-020 The block SHALL apply no saturation: r_data equals mac_out bit-for-bit, and wrap modulo 2^WIDTH_OUT belongs to the MAC.
REQ-021 mac_valid_in SHALL be high for exactly N^3 cycles per job.
REQ-022 The block SHALL tolerate any MAC latency of at least 1 cycle, because result capture is driven only by mac_valid_out.
REQ-023 mac_valid_out while in IDLE SHALL be ignored.

Reset
REQ-024 On rst_n=0, immediately and including mid-job, the state SHALL go to IDLE and all counters to 0.
REQ-025 During reset, busy, done, err, mac_valid_in, mac_clear, r_we, the addresses, mac_inA, mac_inB and r_data SHALL all be 0.
REQ-026 A job interrupted by reset SHALL NOT resume; a new start is required.

Configuration
REQ-027 With MATMUL_SEQ_PERF_EN defined, the block SHALL add an output cycles  32 that clears on an accepted start, increments each cycle while busy, and holds after done.
REQ-028 Without MATMUL_SEQ_PERF_EN, the port and the counter SHALL be absent.

Structure
REQ-029 Package matmul_pkg SHALL hold MAX_SIZE, the address width, the state enum (IDLE/ISSUE/DRAIN/DONE) and the WIDTH_IN/WIDTH_OUT constants.
REQ-030 Sub-module matmul_addr_gen SHALL hold the i/j/k counters, the address arithmetic and the last-triple flag. The FSM, the result counter and the write port SHALL stay in the top module.

Verification
REQ-031 N=2, A=[1,2,3,4], B=identity, 2-cycle MAC model -> r_we at addresses 0..3 with data 1,2,3,4; mac_valid_in high for 8 cycles; one done pulse.
REQ-032 N=3, A=B=[1..9] -> r_data 30,36,42,66,81,96,102,126,150 in address order.
REQ-033 N=10, all elements 255 -> every r_data = 60426 (650250 mod 65536); 100 writes.
REQ-034 size=1, then size=11 -> err pulse each time; busy stays 0; no r_we.
REQ-035 N=3 run, start pulsed mid-ISSUE, then rst_n low mid-DRAIN -> start ignored; all outputs 0 during reset; a following N=2 job runs correctly.
REQ-036 With MATMUL_SEQ_PERF_EN and an N=2, 2-cycle MAC -> cycles equals measured busy duration; value holds after done.
